fill_sequencer: RTL and testbench

Run-time controller for the bottle-filling line. It sequences the pill dispenser and bottle conveyor, and keeps BCD counts of pills in the current bottle and of completed bottles. It raises allFull when the configured bottle target is reached. It sits between the set_MAX configuration registers (per-bottle and bottle-target limits) and the display/music blocks, which consume its counts and allFull.

---
 rtl/fill_pkg.sv | 26 ++
 rtl/bcd2_counter.sv | 26 ++
 rtl/fill_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_fill_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fill_pkg.sv
// Shared types and BCD helper for the bottle-filling run-time sequencer.
// State encoding, BCD digit type and saturating two-digit increment.
package fill_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    PAUSE,
    SWAP_REQ,
    SWAP_REL,
    DONE,
    FAULT
  } state_t;

  // 99 saturates; otherwise L 9->0 carries into H
  function automatic logic [7:0] bcd2_inc(input bcd_t h, input bcd_t l);
    if (h == BCD_MAX && l == BCD_MAX) return {h, l};
    if (l >= BCD_MAX) return {h + 4'd1, 4'd0};
    return {h, l + 4'd1};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter with synchronous clear and saturating increment.
// Clear wins over increment.
module bcd2_counter
  import fill_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output bcd_t q_l,
  output bcd_t q_h
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_h <= '0;
      q_l <= '0;
    end else if (clr) begin
      q_h <= '0;
      q_l <= '0;
    end else if (inc) begin
      {q_h, q_l} <= bcd2_inc(q_h, q_l);
    end
  end

endmodule

// File: rtl/fill_sequencer.sv
// Bottle-filling sequencer: dispenser/conveyor control with BCD counts.
// Optional jam timeout enabled by defining JAM_DETECT_EN.
module fill_sequencer
  import fill_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       EN_work,
  input  logic       EN_set,
  input  logic       isWork,
  input  logic       conti,
  input  logic [3:0] maxL,
  input  logic [3:0] maxH,
  input  logic [3:0] botL,
  input  logic [3:0] botH,
  input  logic       pill_det,
  input  logic       conv_ack,
  output logic       disp_req,
  output logic       conv_req,
  output logic [3:0] nowL,
  output logic [3:0] nowH,
  output logic [3:0] seqL,
  output logic [3:0] seqH,
  output logic       allFull,
  output logic       fault
);

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] pill_sync;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic pill_q;
  logic conti_q;
  logic pill_s;
  logic ack_s;
  logic pill_rise;
  logic conti_rise;
  logic jam_hit;

  logic now_clr, now_inc;
  logic seq_clr, seq_inc;

  logic       cfg_ok;
  logic [7:0] now_v, seq_v;
  logic [7:0] max_v, bot_v;
  logic [7:0] now_nx;

  // Edge history tracks through a freeze so stale edges are dropped
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pill_sync <= '0;
      ack_sync  <= '0;
      pill_q    <= 1'b0;
      conti_q   <= 1'b0;
    end else begin
      pill_sync <= {pill_sync[SYNC_STAGES-2:0], pill_det};
      ack_sync  <= {ack_sync[SYNC_STAGES-2:0], conv_ack};
      pill_q    <= pill_s;
      conti_q   <= conti;
    end
  end

  assign pill_s     = pill_sync[SYNC_STAGES-1];
  assign ack_s      = ack_sync[SYNC_STAGES-1];
  assign pill_rise  = pill_s & ~pill_q & EN_work;
  assign conti_rise = conti & ~conti_q & EN_work;

  assign now_v  = {nowH, nowL};
  assign seq_v  = {seqH, seqL};
  assign max_v  = {maxH, maxL};
  assign bot_v  = {botH, botL};
  assign now_nx = bcd2_inc(nowH, nowL);

  assign cfg_ok = (maxL <= BCD_MAX) && (maxH <= BCD_MAX) &&
                  (botL <= BCD_MAX) && (botH <= BCD_MAX) &&
                  (max_v != 8'h00) && (bot_v != 8'h00);

`ifdef JAM_DETECT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] idle_cnt;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      idle_cnt <= '0;
    end else if (EN_set || state != FILL || pill_rise) begin
      idle_cnt <= '0;
    end else if (EN_work) begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end

  assign jam_hit = EN_work && (idle_cnt == CW'(TIMEOUT_CYC - 1));
  assign fault   = (state == FAULT);
`else
  assign jam_hit = 1'b0;
  assign fault   = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    now_clr = 1'b0;
    now_inc = 1'b0;
    seq_clr = 1'b0;
    seq_inc = 1'b0;
    if (EN_set) begin
      state_n = IDLE;
      now_clr = 1'b1;
      seq_clr = 1'b1;
    end else if (EN_work) begin
      unique case (state)
        IDLE: begin
          if (isWork && cfg_ok) state_n = FILL;
        end
        FILL: begin
          if (pill_rise) begin
            // Lowered limit: swap out without overfilling
            if (now_v >= max_v) begin
              state_n = SWAP_REQ;
            end else begin
              now_inc = 1'b1;
              if (now_nx == max_v) state_n = SWAP_REQ;
              else if (!isWork)    state_n = PAUSE;
            end
          end else if (!isWork) begin
            state_n = PAUSE;
          end else if (jam_hit) begin
            state_n = FAULT;
          end
        end
        PAUSE: begin
          if (isWork) state_n = FILL;
        end
        SWAP_REQ: begin
          if (ack_s) begin
            seq_inc = 1'b1;
            state_n = SWAP_REL;
          end
        end
        SWAP_REL: begin
          if (!ack_s) begin
            if (seq_v >= bot_v) begin
              state_n = DONE;
            end else begin
              now_clr = 1'b1;
              state_n = FILL;
            end
          end
        end
        DONE: begin
          if (conti_rise) begin
            now_clr = 1'b1;
            seq_clr = 1'b1;
            state_n = IDLE;
          end
        end
        FAULT: begin
          if (conti_rise) state_n = FILL;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign disp_req = (state == FILL);
  assign conv_req = (state == SWAP_REQ);
  assign allFull  = (state == DONE);

  bcd2_counter u_now (
    .clk   (CLK),
    .rst_n (RST_n),
    .clr   (now_clr),
    .inc   (now_inc),
    .q_l   (nowL),
    .q_h   (nowH)
  );

  bcd2_counter u_seq (
    .clk   (CLK),
    .rst_n (RST_n),
    .clr   (seq_clr),
    .inc   (seq_inc),
    .q_l   (seqL),
    .q_h   (seqH)
  );

endmodule

// File: tb/tb_fill_sequencer.sv
// Directed bench for fill_sequencer with a four-phase conveyor model.
// Jam-timeout steps build only when JAM_DETECT_EN is defined.
module tb_fill_sequencer;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic       EN_work;
  logic       EN_set;
  logic       isWork;
  logic       conti;
  logic [3:0] maxL, maxH, botL, botH;
  logic       pill_det;
  logic       conv_ack = 1'b0;
  logic       disp_req, conv_req, allFull, fault;
  logic [3:0] nowL, nowH, seqL, seqH;

  int checks   = 0;
  int failures = 0;
  bit model_en = 1'b0;
  int ack_dly  = 0;

  always #5 CLK = ~CLK;

  fill_sequencer #(
    .TIMEOUT_CYC (50),
    .SYNC_STAGES (2)
  ) dut (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .EN_work  (EN_work),
    .EN_set   (EN_set),
    .isWork   (isWork),
    .conti    (conti),
    .maxL     (maxL),
    .maxH     (maxH),
    .botL     (botL),
    .botH     (botH),
    .pill_det (pill_det),
    .conv_ack (conv_ack),
    .disp_req (disp_req),
    .conv_req (conv_req),
    .nowL     (nowL),
    .nowH     (nowH),
    .seqL     (seqL),
    .seqH     (seqH),
    .allFull  (allFull),
    .fault    (fault)
  );

  // Conveyor: ack 4 cycles after request, release after request drops
  always @(negedge CLK) begin
    if (!model_en) begin
      conv_ack = 1'b0;
      ack_dly  = 0;
    end else if (conv_req && !conv_ack) begin
      if (ack_dly == 3) conv_ack = 1'b1;
      else              ack_dly  = ack_dly + 1;
    end else if (!conv_req && conv_ack) begin
      conv_ack = 1'b0;
      ack_dly  = 0;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pill();
    pill_det = 1'b1;
    repeat (2) @(negedge CLK);
    pill_det = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic pills(input int n);
    for (int i = 0; i < n; i++) pill();
  endtask

  task automatic wait_disp();
    for (int i = 0; i < 40 && !disp_req; i++) @(negedge CLK);
  endtask

  initial begin
    RST_n    = 1'b0;
    EN_work  = 1'b1;
    EN_set   = 1'b0;
    isWork   = 1'b1;
    conti    = 1'b0;
    pill_det = 1'b0;
    maxL = 4'd3; maxH = 4'd0;
    botL = 4'd2; botH = 4'd0;

    #1;
    chk("rst_ctl", {12'h0, disp_req, conv_req, allFull, fault}, 16'h0);
    chk("rst_cnt", {nowH, nowL, seqH, seqL}, 16'h0);

    @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);
    chk("idle_to_fill", {15'h0, disp_req}, 16'h1);

    // max=03 bot=02 with conveyor handshakes
    model_en = 1'b1;
    pills(3);
    wait_disp();
    chk("b1_disp", {15'h0, disp_req}, 16'h1);
    chk("b1_cnt", {nowH, nowL, seqH, seqL}, 16'h0001);
    pills(3);
    for (int i = 0; i < 40 && !allFull; i++) @(negedge CLK);
    chk("b2_full", {14'h0, allFull, disp_req}, 16'h2);
    chk("b2_cnt", {nowH, nowL, seqH, seqL}, 16'h0302);
    chk("b2_conv", {15'h0, conv_req}, 16'h0);

    // restart from DONE into max=12 bot=05
    model_en = 1'b0;
    maxL = 4'd2; maxH = 4'd1; botL = 4'd5;
    conti = 1'b1;
    @(negedge CLK);
    chk("conti_clr", {nowH, nowL, seqH, seqL}, 16'h0);
    chk("conti_full", {15'h0, allFull}, 16'h0);
    conti = 1'b0;
    @(negedge CLK);
    chk("refill", {15'h0, disp_req}, 16'h1);

    pills(9);
    chk("now09", {8'h0, nowH, nowL}, 16'h0009);
    pill();
    chk("now10", {8'h0, nowH, nowL}, 16'h0010);
    pill();
    chk("now11", {8'h0, nowH, nowL}, 16'h0011);
    chk("no_req11", {15'h0, conv_req}, 16'h0);
    pill();
    chk("now12", {8'h0, nowH, nowL}, 16'h0012);
    chk("req12", {14'h0, conv_req, disp_req}, 16'h2);
    pill();
    chk("ign_swap", {8'h0, nowH, nowL}, 16'h0012);

    model_en = 1'b1;
    wait_disp();
    model_en = 1'b0;
    chk("b3_cnt", {nowH, nowL, seqH, seqL}, 16'h0001);

    // pause at 04
    pills(4);
    isWork = 1'b0;
    @(negedge CLK);
    chk("pause_disp", {15'h0, disp_req}, 16'h0);
    pills(2);
    chk("pause_ign", {8'h0, nowH, nowL}, 16'h0004);
    isWork = 1'b1;
    @(negedge CLK);
    chk("resume", {7'h0, disp_req, nowH, nowL}, 16'h0104);

    // freeze drops pill edges
    EN_work = 1'b0;
    pill();
    chk("frz_hold", {7'h0, disp_req, nowH, nowL}, 16'h0104);
    EN_work = 1'b1;
    repeat (2) @(negedge CLK);
    chk("frz_drop", {8'h0, nowH, nowL}, 16'h0004);

    // EN_set while requesting swap
    pills(8);
    chk("req_again", {15'h0, conv_req}, 16'h1);
    EN_set = 1'b1;
    @(negedge CLK);
    chk("set_ctl", {14'h0, conv_req, disp_req}, 16'h0);
    chk("set_cnt", {nowH, nowL, seqH, seqL}, 16'h0);
    maxL = 4'hA; maxH = 4'd0;
    @(negedge CLK);
    EN_set = 1'b0;
    repeat (5) @(negedge CLK);
    chk("bad_cfg", {15'h0, disp_req}, 16'h0);
    maxL = 4'd2; maxH = 4'd1;
    @(negedge CLK);
    chk("good_cfg", {15'h0, disp_req}, 16'h1);

    // async reset mid-fill
    pills(5);
    chk("pre_rst", {8'h0, nowH, nowL}, 16'h0005);
    #2 RST_n = 1'b0;
    #1;
    chk("arst_ctl", {12'h0, disp_req, conv_req, allFull, fault}, 16'h0);
    chk("arst_cnt", {nowH, nowL, seqH, seqL}, 16'h0);
    @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);
    chk("post_rst", {7'h0, disp_req, nowH, nowL}, 16'h0100);

`ifdef JAM_DETECT_EN
    repeat (49) @(negedge CLK);
    chk("jam_pre", {15'h0, fault}, 16'h0);
    @(negedge CLK);
    chk("jam_hit", {14'h0, fault, disp_req}, 16'h2);
    conti = 1'b1;
    @(negedge CLK);
    conti = 1'b0;
    chk("jam_clr", {14'h0, fault, disp_req}, 16'h1);
    chk("jam_cnt", {nowH, nowL, seqH, seqL}, 16'h0);
`else
    repeat (60) @(negedge CLK);
    chk("no_jam", {14'h0, fault, disp_req}, 16'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
